// File: rtl/sync_fifo_lifo_if.sv
// Handshake/data bundle between a producer/consumer and the sync_fifo_lifo buffer.
// master = producer/consumer side, slave = buffer side.
interface sync_fifo_lifo_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             mode;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic             err_clr;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             mode_active;
  logic             overflow;
  logic             underflow;

  modport master (
    output mode, push, pop, din, err_clr,
    input  dout, dout_valid, count, full, empty, almost_full, almost_empty,
           mode_active, overflow, underflow
  );

  modport slave (
    input  mode, push, pop, din, err_clr,
    output dout, dout_valid, count, full, empty, almost_full, almost_empty,
           mode_active, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_lifo.sv
// Single-clock FIFO/LIFO buffer with run-time mode select, occupancy flags and same-cycle push+pop.
// Define SYNC_FIFO_LIFO_ERR_EN to build the sticky overflow/underflow error flags.
module sync_fifo_lifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AF_TH = DEPTH - 2,
  parameter int AE_TH = 2
) (
  input logic             clk,
  input logic             reset,
  sync_fifo_lifo_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
  localparam logic [31:0]   AF_C    = 32'(AF_TH);
  localparam logic [31:0]   AE_C    = 32'(AE_TH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] dout_r;
  logic             dout_valid_r;
  logic             full_r;
  logic             empty_r;
  logic             af_r;
  logic             ae_r;
  logic             mode_active_r;

  logic             eff_mode_s;
  logic             pop_ok_s;
  logic             push_ok_s;
  logic [PW-1:0]    wr_inc_s;
  logic [PW-1:0]    wr_dec_s;
  logic [PW-1:0]    rd_inc_s;
  logic [PW-1:0]    wr_idx_s;
  logic [PW-1:0]    rd_idx_s;
  logic [PW-1:0]    wr_ptr_nxt_s;
  logic [PW-1:0]    rd_ptr_nxt_s;
  logic [CW-1:0]    count_nxt_s;

  // Acceptance, pointer and occupancy next-state; LIFO pops from the write end of the same ring.
  always_comb begin
    eff_mode_s   = empty_r ? bus.mode : mode_active_r;
    pop_ok_s     = bus.pop & ~empty_r;
    push_ok_s    = bus.push & (~full_r | pop_ok_s);
    wr_inc_s     = (wr_ptr_r == LAST_C) ? '0 : wr_ptr_r + PW'(1'b1);
    wr_dec_s     = (wr_ptr_r == '0) ? LAST_C : wr_ptr_r - PW'(1'b1);
    rd_inc_s     = (rd_ptr_r == LAST_C) ? '0 : rd_ptr_r + PW'(1'b1);
    wr_idx_s     = wr_ptr_r;
    rd_idx_s     = eff_mode_s ? wr_dec_s : rd_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10: begin
        wr_ptr_nxt_s = wr_inc_s;
        count_nxt_s  = count_r + CW'(1'b1);
      end
      2'b01: begin
        if (eff_mode_s) begin
          wr_ptr_nxt_s = wr_dec_s;
        end else begin
          rd_ptr_nxt_s = rd_inc_s;
        end
        count_nxt_s = count_r - CW'(1'b1);
      end
      2'b11: begin
        // LIFO swap overwrites the top in place; FIFO advances both ends.
        if (eff_mode_s) begin
          wr_idx_s = wr_dec_s;
        end else begin
          wr_ptr_nxt_s = wr_inc_s;
          rd_ptr_nxt_s = rd_inc_s;
        end
      end
      default: begin
        count_nxt_s = count_r;
      end
    endcase
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_idx_s] <= bus.din;
    end
  end

  // Pointers, occupancy, read data, mode and registered flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
      count_r       <= '0;
      dout_r        <= '0;
      dout_valid_r  <= 1'b0;
      full_r        <= 1'b0;
      empty_r       <= 1'b1;
      af_r          <= (AF_C == 32'd0);
      ae_r          <= 1'b1;
      mode_active_r <= 1'b0;
    end else begin
      wr_ptr_r      <= wr_ptr_nxt_s;
      rd_ptr_r      <= rd_ptr_nxt_s;
      count_r       <= count_nxt_s;
      dout_valid_r  <= pop_ok_s;
      if (pop_ok_s) begin
        dout_r <= mem_r[rd_idx_s];
      end else begin
        dout_r <= dout_r;
      end
      full_r        <= (count_nxt_s == DEPTH_C);
      empty_r       <= (count_nxt_s == '0);
      af_r          <= (32'(count_nxt_s) >= AF_C);
      ae_r          <= (32'(count_nxt_s) <= AE_C);
      mode_active_r <= eff_mode_s;
    end
  end

`ifdef SYNC_FIFO_LIFO_ERR_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; a new event in the clearing cycle wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= (bus.push & ~push_ok_s) | (overflow_r & ~bus.err_clr);
      underflow_r <= (bus.pop & ~pop_ok_s) | (underflow_r & ~bus.err_clr);
    end
  end

  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = bus.err_clr;
  assign bus.overflow     = 1'b0;
  assign bus.underflow    = 1'b0;
`endif

  assign bus.dout         = dout_r;
  assign bus.dout_valid   = dout_valid_r;
  assign bus.count        = count_r;
  assign bus.full         = full_r;
  assign bus.empty        = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.mode_active  = mode_active_r;
endmodule
